// File: rtl/ex_mem.sv
// ex_mem: execute-to-memory pipeline register with multiply-accumulate feedback state.
// Revision 1.0
`default_nettype none

module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  // Only the execute and memory stall bits affect this boundary.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  logic bubble;
  logic advance;
  assign bubble  = stall[3] && !stall[4];
  assign advance = !stall[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= '0;
      cnt_o     <= 2'd0;
    end else if (flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= '0;
      cnt_o     <= 2'd0;
    end else if (bubble) begin
      // NOP into memory, but keep the first-cycle madd/msub result alive.
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else if (advance) begin
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_whilo <= ex_whilo;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      hilo_o    <= '0;
      cnt_o     <= 2'd0;
    end
  end

endmodule

`default_nettype wire
